// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit driving a grant/response data-memory bus
//
// Ports:
//   clk_i, rst_ni       clock, synchronous active-low reset
//   ResultSrcM_i        2'b01 marks a load
//   MemWriteM_i         store (wins over load when both are set)
//   Funct3M_i           size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (others act as W)
//   ALUResultM_i        byte address
//   WriteDataM_i        raw store data, low bits significant
//   StallM_o            combinational hold for the F/D/E/M pipeline registers
//   ReadDataM_o         aligned, extended load result, valid in DONE
//   MisalignM_o         misaligned-access flag, valid in DONE
//   dmem_req_o/we_o/addr_o/wdata_o/be_o   registered bus request
//   dmem_gnt_i/rvalid_i/rdata_i           bus grant and read response
//
// Optional feature: define MEM_MISALIGN_CHECK_EN to trap misaligned H/HU/W accesses
// (no bus request, MisalignM_o set in DONE). Without it, addresses are silently aligned.
module mem_stage_lsu #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [1:0]            ResultSrcM_i,
   input  logic                  MemWriteM_i,
   input  logic [2:0]            Funct3M_i,
   input  logic [ADDR_WIDTH-1:0] ALUResultM_i,
   input  logic [DATA_WIDTH-1:0] WriteDataM_i,
   output logic                  StallM_o,
   output logic [DATA_WIDTH-1:0] ReadDataM_o,
   output logic                  MisalignM_o,
   output logic                  dmem_req_o,
   output logic                  dmem_we_o,
   output logic [ADDR_WIDTH-1:0] dmem_addr_o,
   output logic [DATA_WIDTH-1:0] dmem_wdata_o,
   output logic [3:0]            dmem_be_o,
   input  logic                  dmem_gnt_i,
   input  logic                  dmem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] dmem_rdata_i
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
   state_e state_q, state_d;
   logic                  access, is_b, is_h, misalign, start;
   logic [3:0]            be_d, be_q;
   logic [DATA_WIDTH-1:0] wdata_d, wdata_q, rdata_fmt, rdata_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  req_q, we_q, misalign_q;
   logic [2:0]            funct3_q;
   logic [1:0]            off_q;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   assign access = MemWriteM_i | (ResultSrcM_i == 2'b01);
   // funct3[1:0] selects size; reserved encodings fall through to word
   assign is_b   = Funct3M_i[1:0] == 2'b00;
   assign is_h   = Funct3M_i[1:0] == 2'b01;
   assign start  = (state_q == IDLE) & access;
`ifdef MEM_MISALIGN_CHECK_EN
   assign misalign = (is_h & ALUResultM_i[0]) | (~is_b & ~is_h & (ALUResultM_i[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif
   assign be_d    = is_b ? 4'b0001 << ALUResultM_i[1:0] :
                    is_h ? (ALUResultM_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   assign wdata_d = is_b ? {4{WriteDataM_i[7:0]}} :
                    is_h ? {2{WriteDataM_i[15:0]}} : WriteDataM_i;
   // Load formatting uses the size/offset latched at request time
   assign ld_byte   = dmem_rdata_i[{off_q, 3'b000} +: 8];
   assign ld_half   = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
   assign rdata_fmt = (funct3_q[1:0] == 2'b00) ? {{24{~funct3_q[2] & ld_byte[7]}}, ld_byte} :
                      (funct3_q[1:0] == 2'b01) ? {{16{~funct3_q[2] & ld_half[15]}}, ld_half} :
                      dmem_rdata_i;
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (access) state_d = misalign ? DONE : REQ;
         REQ:     if (dmem_gnt_i) state_d = we_q ? DONE : WAIT;
         WAIT:    if (dmem_rvalid_i) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         rdata_q    <= '0;
         misalign_q <= 1'b0;
         funct3_q   <= '0;
         off_q      <= '0;
      end else begin
         state_q    <= state_d;
         misalign_q <= start & misalign;
         if (start & ~misalign) begin
            req_q    <= 1'b1;
            we_q     <= MemWriteM_i;
            addr_q   <= {ALUResultM_i[ADDR_WIDTH-1:2], 2'b00};
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            funct3_q <= Funct3M_i;
            off_q    <= ALUResultM_i[1:0];
         end
         // req drops on the same edge that samples the grant
         if ((state_q == REQ) & dmem_gnt_i) req_q <= 1'b0;
         if ((state_q == WAIT) & dmem_rvalid_i) rdata_q <= rdata_fmt;
         if (start & misalign & ~MemWriteM_i) rdata_q <= '0;
      end
   end
   assign StallM_o     = rst_ni & access & (state_q != DONE);
   assign ReadDataM_o  = rdata_q;
   assign MisalignM_o  = misalign_q;
   assign dmem_req_o   = req_q;
   assign dmem_we_o    = we_q;
   assign dmem_addr_o  = addr_q;
   assign dmem_wdata_o = wdata_q;
   assign dmem_be_o    = be_q;
endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit that consumes the execute-to-memory pipeline register outputs and drives the data-memory bus. Turns each load/store in the M stage into a grant/response bus transaction, formats store data and byte enables, and aligns and extends load data. Holds the pipeline with a stall while a transaction is outstanding, so variable-latency data memory is tolerated.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, data width; only 32 is supported (4 byte lanes)

- clk_i  in  1  clock
- rst_ni  in  1  synchronous reset, active-low
- ResultSrcM_i  in  2  2'b01 marks a load
- MemWriteM_i  in  1  store
- Funct3M_i  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ALUResultM_i  in  ADDR_WIDTH  byte address
- WriteDataM_i  in  DATA_WIDTH  raw store data (low bits significant)
- StallM_o  out  1  combinational; freezes F/D/E/M pipeline registers
- ReadDataM_o  out  DATA_WIDTH  aligned, extended load result
- MisalignM_o  out  1  misaligned access flag (see Configuration)
- dmem_req_o  out  1  bus request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  ADDR_WIDTH  word-aligned address, {addr[31:2],2'b00}
- dmem_wdata_o  out  DATA_WIDTH  lane-replicated store data
- dmem_be_o  out  4  byte enables
- dmem_gnt_i  in  1  request accepted this cycle
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  DATA_WIDTH  read data

## Operation
- Access = store (MemWriteM_i) or load (ResultSrcM_i==01). If both are set, the access is a store.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE with an access: register address, we, wdata and be, then go to REQ. With no access, stay in IDLE.
  - REQ: dmem_req_o=1. On gnt, a store goes to DONE and a load goes to WAIT. Without gnt, stay in REQ with all bus outputs held stable.
  - WAIT: on rvalid, capture the formatted rdata into ReadDataM_o and go to DONE.
  - DONE: StallM_o=0, ReadDataM_o valid for a load. Next state is IDLE.
- StallM_o = access & state!=DONE. Forced to 0 while rst_ni=0.
- The M register advances on every edge where StallM_o=0.
- Store formatting:
  - SB: be=1<<addr[1:0], wdata={4{byte}}
  - SH: be=addr[1]?1100:0011, wdata={2{half}}
  - SW: be=1111
- Load formatting:
  - byte select by addr[1:0], halfword select by addr[1]
  - B/H sign-extend; BU/HU zero-extend
- Reserved funct3 (011, 110, 111) is treated as W.
- rvalid outside WAIT is ignored, and so is gnt outside REQ.
- ReadDataM_o holds its last value outside DONE.
- Reset values: state IDLE; dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_be_o, ReadDataM_o and MisalignM_o all 0.
- Reset mid-transaction: the next edge returns to IDLE with req low. A late rvalid/gnt from the aborted transaction is ignored.

## Timing
- Bus outputs are registered and change only on IDLE→REQ or on leaving REQ. dmem_req_o falls on the edge that samples gnt.
- Store with gnt in the first REQ cycle:
  - cycle 0: IDLE, stall
  - cycle 1: REQ, gnt
  - cycle 2: DONE, no stall
  - Result: 2 stall cycles.
- Load with gnt in the first REQ cycle and rvalid in the first WAIT cycle:
  - cycle 0: IDLE, stall
  - cycle 1: REQ
  - cycle 2: WAIT, rvalid
  - cycle 3: DONE
  - Result: 3 stall cycles.
- Each extra cycle of gnt or rvalid latency adds 1 stall cycle. There is no limit on latency.
- Back-to-back accesses: the next access enters IDLE the cycle after DONE, so there is no bus overlap. At most 1 transaction is outstanding.

## Configuration
- MEM_MISALIGN_CHECK_EN defined:
  - A misaligned access is H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - It issues no bus request and goes IDLE→DONE, giving 1 stall cycle.
  - In DONE: MisalignM_o=1, ReadDataM_o=0 for loads, no write performed.
- MEM_MISALIGN_CHECK_EN undefined:
  - MisalignM_o is tied to 0.
  - H uses addr[1] only and W ignores addr[1:0] (silent alignment).

## Test plan
- SW to 0x100, data 0xDEADBEEF, gnt after 2 cycles -> addr 0x100, be 1111, wdata 0xDEADBEEF; StallM_o high for 3 cycles; req high for exactly 2 cycles.
- SB to 0x103, data 0x000000A5, immediate gnt -> be 1000, wdata 0xA5A5A5A5, 2 stall cycles.
- LB from 0x202 with rdata 0x12F45678 -> ReadDataM_o 0xFFFFFFF4; LBU gives 0x000000F4; LHU from 0x202 gives 0x000012F4.
- LW, rvalid delayed 4 cycles, stray rvalid while IDLE beforehand -> stray ignored; ReadDataM_o = rdata in DONE only; stall = 2+4 cycles.
- rst_ni low during WAIT, then rvalid after reset -> req 0, state IDLE, ReadDataM_o stays 0, StallM_o 0.
- MEM_MISALIGN_CHECK_EN: LW at 0x301 -> no req, MisalignM_o=1 for 1 cycle, ReadDataM_o 0. Without the macro: access at 0x300, MisalignM_o 0.
